record_core: RTL and testbench

//  Captures stereo samples from the audio codec (valid/ready) and stores them to SDRAM so the

---
 rtl/audio_mem_pkg.sv | 16 +
 rtl/record_core_if.sv | 28 ++
 rtl/record_core.sv | 126 ++++++++++++
 tb/tb_record_core.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_mem_pkg.sv
// Definitions shared by the audio record and playback cores: bus widths, record FSM states
// and the recording slot layout (header word = data-word count, zero-extended).
package audio_mem_pkg;

   localparam int AM_ADDR_W = 23;
   localparam int AM_DATA_W = 32;
   localparam logic [AM_ADDR_W-1:0] AM_MAX_LEN = 23'h0FFFFF;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'b00,
      ST_CAPTURE    = 2'b01,
      ST_WRITE_DATA = 2'b10,
      ST_WRITE_LEN  = 2'b11
   } rec_state_e;

endpackage

// File: rtl/record_core_if.sv
// SDRAM arbiter write port and codec RX sample stream as seen by record_core.
interface record_core_if
   import audio_mem_pkg::*;
#(
   parameter int ADDR_W = AM_ADDR_W,
   parameter int DATA_W = AM_DATA_W
);
   // A codec sample transfers on a cycle with rec_audio_valid && rec_audio_ready. An SDRAM write
   // transfers on a cycle with rec_write && rec_sdram_finished; address and data hold until then.
   logic              rec_write;
   logic [ADDR_W-1:0] rec_addr;
   logic [DATA_W-1:0] rec_writedata;
   logic              rec_sdram_finished;
   logic              rec_audio_valid;
   logic [DATA_W-1:0] rec_audio_data;
   logic              rec_audio_ready;

   modport master (
      output rec_write, rec_addr, rec_writedata, rec_audio_ready,
      input  rec_sdram_finished, rec_audio_valid, rec_audio_data
   );

   modport slave (
      input  rec_write, rec_addr, rec_writedata, rec_audio_ready,
      output rec_sdram_finished, rec_audio_valid, rec_audio_data
   );

endinterface

// File: rtl/record_core.sv
// Records codec samples into an SDRAM slot: one data word kept per two accepted samples, then a
// header word holding the data-word count is written at the slot base address.
module record_core
   import audio_mem_pkg::*;
#(
   parameter int                ADDR_W  = AM_ADDR_W,
   parameter int                DATA_W  = AM_DATA_W,
   parameter logic [ADDR_W-1:0] MAX_LEN = ADDR_W'(AM_MAX_LEN)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              rec_start,
   input  logic [ADDR_W-1:0] rec_select,
   input  logic              rec_pause,
   input  logic              rec_stop,
   output logic              rec_done,
   output logic [1:0]        debug,
   record_core_if.master     bus
);

   rec_state_e        state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic              phase_q, phase_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              stop_pend_q, stop_pend_d;
   logic [ADDR_W-1:0] count_inc;
   logic              last_word;

   assign debug     = state_q;
   assign count_inc = count_q + ADDR_W'(1);
   // The slot ends at the top of the address space rather than wrapping onto low memory.
   assign last_word = (count_inc == MAX_LEN) || (&addr_q);

   always_comb begin
      state_d              = state_q;
      base_d               = base_q;
      addr_d               = addr_q;
      count_d              = count_q;
      phase_d              = phase_q;
      data_d               = data_q;
      stop_pend_d          = stop_pend_q;
      rec_done             = 1'b0;
      bus.rec_write        = 1'b0;
      bus.rec_addr         = '0;
      bus.rec_writedata    = '0;
      bus.rec_audio_ready  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (rec_start) begin
               base_d      = rec_select;
               addr_d      = rec_select + ADDR_W'(1);
               count_d     = '0;
               phase_d     = 1'b0;
               stop_pend_d = 1'b0;
               state_d     = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            bus.rec_audio_ready = !rec_pause;
            // Stop takes priority over a coincident sample, and an incomplete pair is dropped.
            if (rec_stop) begin
               phase_d = 1'b0;
               state_d = ST_WRITE_LEN;
            end else if (bus.rec_audio_valid && !rec_pause) begin
               if (!phase_q) begin
                  data_d  = bus.rec_audio_data;
                  phase_d = 1'b1;
               end else begin
                  phase_d = 1'b0;
                  state_d = ST_WRITE_DATA;
               end
            end
         end
         ST_WRITE_DATA: begin
            bus.rec_write     = 1'b1;
            bus.rec_addr      = addr_q;
            bus.rec_writedata = data_q;
            if (rec_stop) stop_pend_d = 1'b1;
            if (bus.rec_sdram_finished) begin
               addr_d  = addr_q + ADDR_W'(1);
               count_d = count_inc;
               if (last_word || rec_stop || stop_pend_q) begin
                  stop_pend_d = 1'b0;
                  state_d     = ST_WRITE_LEN;
               end else begin
                  state_d = ST_CAPTURE;
               end
            end
         end
         ST_WRITE_LEN: begin
            bus.rec_write     = 1'b1;
            bus.rec_addr      = base_q;
            bus.rec_writedata = {{(DATA_W-ADDR_W){1'b0}}, count_q};
            if (bus.rec_sdram_finished) begin
               rec_done = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         base_q      <= '0;
         addr_q      <= '0;
         count_q     <= '0;
         phase_q     <= 1'b0;
         data_q      <= '0;
         stop_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         addr_q      <= addr_d;
         count_q     <= count_d;
         phase_q     <= phase_d;
         data_q      <= data_d;
         stop_pend_q <= stop_pend_d;
      end
   end

endmodule

// File: tb/tb_record_core.sv
// Bench for record_core: a per-cycle vector table, directed multi-cycle sequences, a MAX_LEN=4
// instance, and randomized recordings scored against a model of the slot layout.
module tb_record_core;
   import audio_mem_pkg::*;

   localparam int AW = AM_ADDR_W;
   localparam int DW = AM_DATA_W;
   localparam int EW = 1 + AW + DW;
   localparam int MAX_A = int'(AM_MAX_LEN);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          start_a = 0, pause_a = 0, stop_a = 0, done_a;
   logic [AW-1:0] sel_a = '0;
   logic [1:0]    debug_a;
   logic          start_b = 0, pause_b = 0, stop_b = 0, done_b;
   logic [AW-1:0] sel_b = '0;
   logic [1:0]    debug_b;

   record_core_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
   record_core_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

   record_core u_dut_a (
      .i_clk(clk), .i_rst(rst), .rec_start(start_a), .rec_select(sel_a), .rec_pause(pause_a),
      .rec_stop(stop_a), .rec_done(done_a), .debug(debug_a), .bus(bus_a)
   );

   record_core #(.MAX_LEN(23'd4)) u_dut_b (
      .i_clk(clk), .i_rst(rst), .rec_start(start_b), .rec_select(sel_b), .rec_pause(pause_b),
      .rec_stop(stop_b), .rec_done(done_b), .debug(debug_b), .bus(bus_b)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [EW-1:0] obs_a[$];
   logic [EW-1:0] obs_b[$];
   logic [DW-1:0] acc_a[$];
   int            done_cnt_a = 0;
   int            done_cnt_b = 0;

   int   lat_a     = 1;
   logic man_a     = 1'b0;
   logic fin_man_a = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // ---------------- SDRAM responders ----------------
   initial begin
      int wcnt = 0;
      bus_a.rec_sdram_finished = 1'b0;
      forever begin
         @(posedge clk); #2;
         if (man_a) begin
            bus_a.rec_sdram_finished = fin_man_a;
         end else begin
            bus_a.rec_sdram_finished = 1'b0;
            if (bus_a.rec_write) begin
               wcnt++;
               if (wcnt >= lat_a) begin
                  bus_a.rec_sdram_finished = 1'b1;
                  wcnt = 0;
               end
            end else begin
               wcnt = 0;
            end
         end
      end
   end

   initial begin
      bus_b.rec_sdram_finished = 1'b0;
      forever begin
         @(posedge clk); #2;
         bus_b.rec_sdram_finished = bus_b.rec_write;
      end
   end

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      if (!rst) begin
         if (bus_a.rec_write && bus_a.rec_sdram_finished)
            obs_a.push_back({done_a, bus_a.rec_addr, bus_a.rec_writedata});
         if (done_a) done_cnt_a++;
         if (bus_a.rec_audio_valid && bus_a.rec_audio_ready && !stop_a)
            acc_a.push_back(bus_a.rec_audio_data);
         if (pause_a) check("pause_ready", 64'(bus_a.rec_audio_ready), 64'd0);
         if (bus_b.rec_write && bus_b.rec_sdram_finished)
            obs_b.push_back({done_b, bus_b.rec_addr, bus_b.rec_writedata});
         if (done_b) done_cnt_b++;
      end
   end

   // ---------------- driver tasks (called at #1 after a rising edge) ----------------
   task automatic reset_all();
      rst = 1'b1;
      start_a = 0; stop_a = 0; pause_a = 0;
      bus_a.rec_audio_valid = 0; bus_a.rec_audio_data = '0;
      start_b = 0; stop_b = 0; pause_b = 0;
      bus_b.rec_audio_valid = 0; bus_b.rec_audio_data = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      obs_a.delete(); acc_a.delete(); obs_b.delete();
      done_cnt_a = 0; done_cnt_b = 0;
   endtask

   task automatic start_rec_a(input logic [AW-1:0] sel);
      start_a = 1'b1; sel_a = sel;
      @(posedge clk); #1 start_a = 1'b0;
   endtask

   task automatic send_a(input logic [DW-1:0] d, input string tag);
      int n = 0;
      bus_a.rec_audio_valid = 1'b1;
      bus_a.rec_audio_data  = d;
      do begin
         @(negedge clk);
         n++;
      end while (!bus_a.rec_audio_ready && n < 200);
      if (n >= 200) check({tag, "_send_timeout"}, 64'(n), 64'd0);
      @(posedge clk); #1 bus_a.rec_audio_valid = 1'b0;
   endtask

   task automatic stop_pulse_a();
      bus_a.rec_audio_valid = 1'b0;
      stop_a = 1'b1;
      @(posedge clk); #1 stop_a = 1'b0;
   endtask

   task automatic wait_idle_a(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (debug_a != 2'd0 && n < 500);
      check({tag, "_idle_timeout"}, 64'(n < 500), 64'd1);
      @(posedge clk); #1;
   endtask

   // ---------------- scoreboard ----------------
   // Expected slot image: data words are the first sample of each complete pair, capped by MAX_LEN
   // and by the space left before the top address; the header closes the recording with rec_done.
   task automatic check_rec_a(input logic [AW-1:0] base, input int maxlen, input string tag);
      logic [EW-1:0] exp_q[$];
      int            n    = acc_a.size() / 2;
      int            room = ((2 ** AW) - 1) - int'(base);
      logic [AW-1:0] a;
      if (n > maxlen) n = maxlen;
      if (n > room) n = room;
      for (int i = 0; i < n; i++) begin
         a = base + AW'(i + 1);
         exp_q.push_back({1'b0, a, acc_a[2*i]});
      end
      exp_q.push_back({1'b1, base, DW'(n)});
      check({tag, "_nwrites"}, 64'(obs_a.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_a.size(); i++)
         check($sformatf("%s_write%0d", tag, i), 64'(obs_a[i]), 64'(exp_q[i]));
      check({tag, "_done_pulses"}, 64'(done_cnt_a), 64'd1);
      obs_a.delete(); acc_a.delete(); done_cnt_a = 0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic start, pause, stop, valid, fin;
      logic [DW-1:0] data;
      logic [1:0]    e_state;
      logic          e_ready, e_write, e_done;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wdata;
   } vec_t;

   function automatic vec_t mk(input logic st, pa, sp, va, fi, input logic [DW-1:0] d,
                               input logic [1:0] es, input logic er, ew, ed,
                               input logic [AW-1:0] ea, input logic [DW-1:0] wd);
      vec_t v;
      v.start = st; v.pause = pa; v.stop = sp; v.valid = va; v.fin = fi; v.data = d;
      v.e_state = es; v.e_ready = er; v.e_write = ew; v.e_done = ed; v.e_addr = ea; v.e_wdata = wd;
      return v;
   endfunction

   vec_t vecs[14];

   initial begin
      logic          hs;
      logic          seen;
      logic [AW-1:0] base;
      int            n;

      // Inputs this cycle -> outputs this cycle; slot at 0x200.
      vecs[0]  = mk(1,0,0,0,0, 32'h00, 2'd0, 0,0,0, 23'h000, 32'h00);
      vecs[1]  = mk(0,0,0,1,0, 32'h11, 2'd1, 1,0,0, 23'h000, 32'h00);
      vecs[2]  = mk(0,1,0,1,0, 32'h22, 2'd1, 0,0,0, 23'h000, 32'h00);
      vecs[3]  = mk(0,0,0,1,0, 32'h22, 2'd1, 1,0,0, 23'h000, 32'h00);
      vecs[4]  = mk(0,0,0,0,0, 32'h00, 2'd2, 0,1,0, 23'h201, 32'h11);
      vecs[5]  = mk(1,0,0,1,0, 32'h33, 2'd2, 0,1,0, 23'h201, 32'h11);
      vecs[6]  = mk(0,0,0,0,1, 32'h00, 2'd2, 0,1,0, 23'h201, 32'h11);
      vecs[7]  = mk(0,0,0,1,0, 32'h33, 2'd1, 1,0,0, 23'h000, 32'h00);
      vecs[8]  = mk(0,0,1,1,0, 32'h44, 2'd1, 1,0,0, 23'h000, 32'h00);
      vecs[9]  = mk(0,0,0,0,0, 32'h00, 2'd3, 0,1,0, 23'h200, 32'h01);
      vecs[10] = mk(0,0,0,0,1, 32'h00, 2'd3, 0,1,1, 23'h200, 32'h01);
      vecs[11] = mk(0,0,0,0,0, 32'h00, 2'd0, 0,0,0, 23'h000, 32'h00);
      vecs[12] = mk(0,1,1,1,0, 32'h55, 2'd0, 0,0,0, 23'h000, 32'h00);
      vecs[13] = mk(0,0,0,0,0, 32'h00, 2'd0, 0,0,0, 23'h000, 32'h00);

      bus_a.rec_audio_valid = 0; bus_a.rec_audio_data = '0;
      bus_b.rec_audio_valid = 0; bus_b.rec_audio_data = '0;
      @(posedge clk); #1;
      reset_all();

      // Reset state of both instances.
      @(negedge clk);
      check("reset_a", {debug_a, bus_a.rec_audio_ready, bus_a.rec_write, done_a, bus_a.rec_addr,
                        bus_a.rec_writedata}, 64'd0);
      check("reset_b", {debug_b, bus_b.rec_audio_ready, bus_b.rec_write, done_b, bus_b.rec_addr,
                        bus_b.rec_writedata}, 64'd0);
      @(posedge clk); #1;

      man_a = 1'b1;
      sel_a = 23'h200;
      for (int i = 0; i < 14; i++) begin
         start_a = vecs[i].start; pause_a = vecs[i].pause; stop_a = vecs[i].stop;
         bus_a.rec_audio_valid = vecs[i].valid; bus_a.rec_audio_data = vecs[i].data;
         fin_man_a = vecs[i].fin;
         @(negedge clk);
         check($sformatf("vec%0d", i),
               {debug_a, bus_a.rec_audio_ready, bus_a.rec_write, done_a, bus_a.rec_addr, bus_a.rec_writedata},
               {vecs[i].e_state, vecs[i].e_ready, vecs[i].e_write, vecs[i].e_done, vecs[i].e_addr, vecs[i].e_wdata});
         @(posedge clk); #1;
      end
      start_a = 0; pause_a = 0; stop_a = 0; bus_a.rec_audio_valid = 0; fin_man_a = 0; man_a = 1'b0;
      check_rec_a(23'h200, MAX_A, "table");

      // Six samples, SDRAM latency 3, then stop.
      lat_a = 3;
      start_rec_a(23'h100);
      for (int i = 0; i < 6; i++) send_a(32'hAAAA_0000 + DW'(i), "t1");
      stop_pulse_a();
      wait_idle_a("t1");
      check("t1_header", obs_a.size() > 0 ? 64'(obs_a[obs_a.size()-1]) : 64'd0,
            64'({1'b1, 23'h100, 32'd3}));
      check_rec_a(23'h100, MAX_A, "t1");

      // Stop after half a pair: empty recording.
      start_rec_a(23'h100);
      send_a(32'hBBBB_0001, "t2");
      stop_pulse_a();
      wait_idle_a("t2");
      check_rec_a(23'h100, MAX_A, "t2");

      // Pause for 10 cycles with a sample waiting.
      lat_a = 2;
      start_rec_a(23'h300);
      for (int i = 0; i < 3; i++) send_a(32'hCCCC_0000 + DW'(i), "t3");
      pause_a = 1'b1;
      bus_a.rec_audio_valid = 1'b1; bus_a.rec_audio_data = 32'hCCCC_0003;
      repeat (10) begin
         @(negedge clk);
         check("t3_ready_paused", 64'(bus_a.rec_audio_ready), 64'd0);
      end
      @(posedge clk); #1 pause_a = 1'b0;
      for (int i = 3; i < 6; i++) send_a(32'hCCCC_0000 + DW'(i), "t3");
      stop_pulse_a();
      wait_idle_a("t3");
      check_rec_a(23'h300, MAX_A, "t3");

      // Stop while a data write is still outstanding.
      lat_a = 8;
      start_rec_a(23'h400);
      send_a(32'hDDDD_0000, "t4");
      send_a(32'hDDDD_0001, "t4");
      @(negedge clk);
      check("t4_in_write_data", 64'(debug_a), 64'd2);
      @(posedge clk); #1;
      stop_pulse_a();
      @(negedge clk);
      check("t4_still_write_data", 64'(debug_a), 64'd2);
      @(posedge clk); #1;
      wait_idle_a("t4");
      check_rec_a(23'h400, MAX_A, "t4");

      // MAX_LEN=4 instance with continuous samples ends by itself.
      start_b = 1'b1; sel_b = 23'h040;
      bus_b.rec_audio_valid = 1'b1; bus_b.rec_audio_data = 32'h1000;
      @(posedge clk); #1 start_b = 1'b0;
      seen = 1'b0; n = 0;
      while (!seen && n < 200) begin
         @(negedge clk);
         hs = bus_b.rec_audio_valid && bus_b.rec_audio_ready;
         seen = done_b;
         n++;
         @(posedge clk); #1;
         if (hs) bus_b.rec_audio_data = bus_b.rec_audio_data + 32'd1;
      end
      check("t5_done_seen", 64'(seen), 64'd1);
      repeat (3) @(posedge clk);
      #1 bus_b.rec_audio_valid = 1'b0;
      check("t5_nwrites", 64'(obs_b.size()), 64'd5);
      for (int i = 0; i < 4 && i < obs_b.size(); i++)
         check($sformatf("t5_write%0d", i), 64'(obs_b[i]),
               64'({1'b0, 23'h041 + 23'(i), 32'h1000 + 32'(2 * i)}));
      check("t5_header", obs_b.size() > 4 ? 64'(obs_b[4]) : 64'd0, 64'({1'b1, 23'h040, 32'd4}));
      check("t5_done_pulses", 64'(done_cnt_b), 64'd1);
      @(negedge clk);
      check("t5_idle", {debug_b, bus_b.rec_audio_ready}, 64'd0);
      @(posedge clk); #1;

      // Reset during a data write abandons the recording.
      lat_a = 50;
      start_rec_a(23'h500);
      send_a(32'hEEEE_0000, "t6");
      send_a(32'hEEEE_0001, "t6");
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("t6_after_reset", {debug_a, bus_a.rec_write}, 64'd0);
      @(posedge clk); #1;
      check("t6_no_writes", 64'(obs_a.size()), 64'd0);
      check("t6_no_done", 64'(done_cnt_a), 64'd0);
      acc_a.delete();
      lat_a = 2;
      start_rec_a(23'h600);
      for (int i = 0; i < 4; i++) send_a(32'hEEEE_1000 + DW'(i), "t6");
      stop_pulse_a();
      wait_idle_a("t6");
      check_rec_a(23'h600, MAX_A, "t6");

      // Randomized recordings; the first slot sits just below the top address.
      for (int r = 0; r < 8; r++) begin
         base  = (r == 0) ? 23'h7FFFFD : AW'($urandom_range(0, 32'h007F_FF00));
         lat_a = $urandom_range(1, 4);
         start_rec_a(base);
         for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            hs = bus_a.rec_audio_valid && bus_a.rec_audio_ready;
            @(posedge clk); #1;
            if (!bus_a.rec_audio_valid || hs) begin
               bus_a.rec_audio_valid = ($urandom_range(0, 3) != 0);
               bus_a.rec_audio_data  = $urandom;
            end
            pause_a = ($urandom_range(0, 4) == 0);
         end
         pause_a = 1'b0;
         stop_pulse_a();
         wait_idle_a($sformatf("rand%0d", r));
         check_rec_a(base, MAX_A, $sformatf("rand%0d", r));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule
